oled_spi_rx: RTL and testbench

// - Receiving end of the SSD1306 OLED SPI link (SPI mode 0, MSB first, DC-qualified bytes), sampled in the system clock domain.
// - Deserialises the SCK/MOSI/CS/DC stream that the core drives to the panel.
// - Tags each data byte with its horizontal-mode frame address (page*128+col) and queues {dc, addr, byte} for a frame-buffer or capture consumer.
// - Used for display mirroring and bench capture.

---
 rtl/oled_spi_rx_pkg.sv | 19 +
 rtl/oled_rx_fifo.sv | 62 ++++++
 rtl/oled_spi_rx.sv | 142 ++++++++++++++
 tb/tb_oled_spi_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/oled_spi_rx_pkg.sv
// Shared constants and the FIFO entry layout for the SSD1306 SPI receiver.
package oled_spi_rx_pkg;

   localparam int unsigned OLED_COLS   = 128;
   localparam int unsigned OLED_PAGES  = 8;
   localparam int unsigned OLED_ADDR_W = 10;
   localparam int unsigned OLED_BYTE_W = 8;

   localparam logic [OLED_ADDR_W-1:0] OLED_LAST_ADDR = OLED_ADDR_W'(OLED_COLS * OLED_PAGES - 1);

   typedef struct packed {
      logic                   dc;
      logic [OLED_ADDR_W-1:0] addr;
      logic [OLED_BYTE_W-1:0] data;
   } oled_entry_t;

   localparam int unsigned OLED_ENTRY_W = $bits(oled_entry_t);

endpackage

// File: rtl/oled_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head is read straight from the storage registers.
module oled_rx_fifo #(
   parameter int unsigned AW = 2,
   parameter int unsigned W  = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] data_o,
   output logic         valid_o,
   output logic         full_o
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          wr_en;
   logic          rd_en;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign valid_o = (cnt_q != '0);
   assign data_o  = mem_q[rd_ptr_q];

   // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
   assign wr_en = push_i && (!full_o || pop_i);
   assign rd_en = pop_i && valid_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/oled_spi_rx.sv
// SSD1306 SPI (mode 0, MSB first) receiver: deserialises bytes, tags them with the
// horizontal-mode frame address and queues {dc, addr, byte} for a consumer.
module oled_spi_rx
   import oled_spi_rx_pkg::*;
#(
   parameter int unsigned FIFO_AW     = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   spi_sck,
   input  logic                   spi_mosi,
   input  logic                   spi_cs_n,
   input  logic                   spi_dc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OLED_BYTE_W-1:0] out_data,
   output logic                   out_dc,
   output logic [OLED_ADDR_W-1:0] out_addr,
   output logic                   overflow,
   input  logic                   ovf_clr,
   output logic                   frame_done
);

   localparam int unsigned SL = SYNC_STAGES - 1;

   logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
   logic                   sck_prev_q, rise_q, mosi_q, cs_q, dc_q;

   logic [OLED_BYTE_W-1:0] shift_q, shift_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [OLED_ADDR_W-1:0] addr_q, addr_d;
   logic                   overflow_q, overflow_d;
   logic                   frame_done_q, frame_done_d;

   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_valid;
   oled_entry_t             push_entry;
   oled_entry_t             head_entry;
   logic [OLED_ENTRY_W-1:0] head_bits;

   // Input synchronisers; cs_n idles high so a reset never looks like an active frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         dc_sync_q   <= '0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  spi_sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
         dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0],   spi_dc};
      end
   end

   // Registered SCK rising-edge strobe with mosi/cs/dc kept aligned to it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sck_prev_q <= 1'b0;
         rise_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_q       <= 1'b1;
         dc_q       <= 1'b0;
      end else begin
         sck_prev_q <= sck_sync_q[SL];
         rise_q     <= sck_sync_q[SL] & ~sck_prev_q;
         mosi_q     <= mosi_sync_q[SL];
         cs_q       <= cs_sync_q[SL];
         dc_q       <= dc_sync_q[SL];
      end
   end

   assign pop = out_ready && fifo_valid;

   always_comb begin
      shift_d         = shift_q;
      bit_cnt_d       = bit_cnt_q;
      addr_d          = addr_q;
      frame_done_d    = 1'b0;
      push            = 1'b0;
      push_entry.dc   = dc_q;
      push_entry.addr = addr_q;
      push_entry.data = {shift_q[6:0], mosi_q};
      if (cs_q) begin
         bit_cnt_d = '0;
      end else if (rise_q) begin
         shift_d   = {shift_q[6:0], mosi_q};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            push         = 1'b1;
            addr_d       = dc_q ? addr_q + OLED_ADDR_W'(1) : '0;
            frame_done_d = dc_q && (addr_q == OLED_LAST_ADDR);
         end
      end
      // A drop sets the flag even when a clear arrives in the same cycle.
      overflow_d = overflow_q;
      if (push && fifo_full && !pop) overflow_d = 1'b1;
      else if (ovf_clr)              overflow_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         addr_q       <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         addr_q       <= addr_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   oled_rx_fifo #(
      .AW (FIFO_AW),
      .W  (OLED_ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head_bits),
      .valid_o (fifo_valid),
      .full_o  (fifo_full)
   );

   assign head_entry = oled_entry_t'(head_bits);
   assign out_valid  = fifo_valid;
   assign out_data   = head_entry.data;
   assign out_dc     = head_entry.dc;
   assign out_addr   = head_entry.addr;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: drives SPI mode-0 bytes and checks the queued entries.
module tb_oled_spi_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       spi_sck = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_dc = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_dc;
   logic [9:0] out_addr;
   logic       overflow;
   logic       ovf_clr = 1'b0;
   logic       frame_done;

   int total = 0;
   int bad   = 0;

   logic       mon_en = 1'b0;
   int         fd_cnt = 0;
   int         pops = 0;
   logic [9:0] last_addr = '0;
   logic [7:0] last_data = '0;

   always #5 clk = ~clk;

   oled_spi_rx #(.FIFO_AW(2), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_cs_n   (spi_cs_n),
      .spi_dc     (spi_dc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_dc     (out_dc),
      .out_addr   (out_addr),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .frame_done (frame_done)
   );

   always @(negedge clk) begin
      if (mon_en) begin
         if (frame_done === 1'b1) fd_cnt++;
         if (out_valid && out_ready) begin
            pops++;
            last_addr = out_addr;
            last_data = out_data;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
      spi_dc = dc;
      for (int i = 7; i > 7 - n; i--) begin
         spi_mosi = b[i];
         tick(2);
         spi_sck = 1'b1;
         tick(2);
         spi_sck = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      send_bits(b, 8, dc);
      tick(4);
   endtask

   task automatic head(input string tag, input logic dc, input logic [9:0] addr, input logic [7:0] data);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_dc"},    32'(out_dc),    32'(dc));
      chk({tag, "_addr"},  32'(out_addr),  32'(addr));
      chk({tag, "_data"},  32'(out_data),  32'(data));
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   initial begin
      // reset values
      tick(2);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      rst = 1'b1;
      tick(2);
      spi_cs_n = 1'b0;
      tick(4);

      // command 0xAE with latency check: visible SYNC_STAGES+2 clocks after the 8th rising edge
      send_bits(8'hAE, 7, 1'b0);
      spi_mosi = 1'b0;
      tick(2);
      spi_sck = 1'b1;
      tick(3);
      chk("lat_early", 32'(out_valid), 32'd0);
      tick(1);
      chk("lat_on", 32'(out_valid), 32'd1);
      spi_sck = 1'b0;
      tick(2);
      head("cmd_ae", 1'b0, 10'd0, 8'hAE);

      // two data bytes
      send_byte(8'h5A, 1'b1);
      send_byte(8'hC3, 1'b1);
      head("d5a", 1'b1, 10'd0, 8'h5A);
      head("dc3", 1'b1, 10'd1, 8'hC3);
      chk("d_empty", 32'(out_valid), 32'd0);

      // command resets address; then a full 1024-byte frame
      send_byte(8'h00, 1'b0);
      head("cmd00", 1'b0, 10'd2, 8'h00);
      mon_en = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 1024; i++) send_byte(8'(i), 1'b1);
      tick(4);
      mon_en = 1'b0;
      out_ready = 1'b0;
      chk("frm_pops", 32'(pops), 32'd1024);
      chk("frm_last_addr", 32'(last_addr), 32'd1023);
      chk("frm_last_data", 32'(last_data), 32'hFF);
      chk("frm_done_cnt", 32'(fd_cnt), 32'd1);
      send_byte(8'h11, 1'b1);
      head("wrap", 1'b1, 10'd0, 8'h11);

      // partial byte aborted by cs_n high
      send_bits(8'hFF, 3, 1'b1);
      spi_cs_n = 1'b1;
      tick(4);
      spi_cs_n = 1'b0;
      tick(2);
      send_byte(8'h81, 1'b1);
      head("abort", 1'b1, 10'd1, 8'h81);
      chk("abort_empty", 32'(out_valid), 32'd0);

      // overflow: six bytes into four slots
      for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b1);
      chk("ovf_set", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);
      // clear coincides with the push of a dropped byte
      send_bits(8'h16, 7, 1'b1);
      spi_mosi = 1'b0;
      tick(2);
      spi_sck = 1'b1;
      tick(3);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("ovf_prio", 32'(overflow), 32'd1);
      spi_sck = 1'b0;
      tick(4);
      for (int i = 0; i < 4; i++) head("ovf_q", 1'b1, 10'(2 + i), 8'(8'h10 + i));
      chk("ovf_empty", 32'(out_valid), 32'd0);
      send_byte(8'hB0, 1'b0);
      head("cmd_b0", 1'b0, 10'd9, 8'hB0);

      // command tagging after data at address 5
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b1);
      out_ready = 1'b0;
      send_byte(8'h55, 1'b1);
      send_byte(8'h21, 1'b0);
      send_byte(8'h77, 1'b1);
      head("d55", 1'b1, 10'd5, 8'h55);
      head("cmd21", 1'b0, 10'd6, 8'h21);
      head("d77", 1'b1, 10'd0, 8'h77);

      // asynchronous reset mid-byte
      send_byte(8'h99, 1'b1);
      send_bits(8'hF0, 4, 1'b1);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      chk("pre_rst_ovf", 32'(overflow), 32'd1);
      rst = 1'b0;
      #2;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      chk("mid_rst_fd", 32'(frame_done), 32'd0);
      tick(2);
      rst = 1'b1;
      tick(2);
      spi_cs_n = 1'b1;
      tick(4);
      spi_cs_n = 1'b0;
      tick(2);
      send_byte(8'h3C, 1'b1);
      head("post_rst", 1'b1, 10'd0, 8'h3C);
      chk("post_rst_empty", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
